wb_stage: RTL and testbench
===========================

# wb_stage

Parametrised, sequential write-back stage for the multi-cycle core. It selects the write-back value from `NUM_SRC` candidate sources and applies RISC-V load byte/half extraction and sign/zero extension to memory data. It waits for late memory read data and then issues a single-cycle register-file write. It sits between the execute/memory phases and the register file, and replaces the two-input ALU/memory write-back selector.

## Interface
Parameters:
- `DATA_W`, default 32: datapath width; must be ≥ 32.
- `NUM_SRC`, default 4: number of write-back sources; must be ≥ 2.
- `MEM_IDX`, default 1: source index carrying raw memory read data; must be < `NUM_SRC`.
- `SEL_W`, default `$clog2(NUM_SRC)`: select width.
- `RA_W`, default 5: register address width.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `in_valid`, in, 1: write-back request.
- `in_ready`, out, 1: stage can accept a request.
- `wb_sel`, in, `SEL_W`: source select.
- `src_data`, in, `NUM_SRC*DATA_W`: packed sources; source i is bits [i*DATA_W +: DATA_W].
- `rd_addr`, in, `RA_W`: destination register.
- `rd_we`, in, 1: instruction writes rd.
- `ld_mode`, in, 3: funct3 of the load.
- `addr_lo`, in, 2: low bits of the load address.
- `mem_rvalid`, in, 1: memory read data valid.
- `mem_rdata`, in, `DATA_W`: memory read data, used when `wb_sel==MEM_IDX`.
- `rf_we`, out, 1: register-file write strobe.
- `rf_waddr`, out, `RA_W`: register-file write address.
- `rf_wdata`, out, `DATA_W`: register-file write data.
- `sel_err`, out, 1: one-cycle pulse when `wb_sel >= NUM_SRC` is accepted.

## Operation
The stage is a three-state FSM: IDLE, WAIT_MEM, WRITE. `in_ready` is 1 only in IDLE.

IDLE, on `in_valid`:
- Latch `rd_addr`, `rd_we`, `ld_mode`, `addr_lo`, `wb_sel`.
- If `wb_sel != MEM_IDX`: latch the selected source and go to WRITE.
- If `wb_sel == MEM_IDX` and `mem_rvalid` is 1 in the same cycle: latch the extended `mem_rdata` and go to WRITE.
- If `wb_sel == MEM_IDX` and `mem_rvalid` is 0: go to WAIT_MEM.
- If `wb_sel >= NUM_SRC`: the data is 0, `sel_err` pulses next cycle, and the stage goes to WRITE.

`mem_rvalid` is ignored in IDLE without an accepted MEM request, and ignored in WRITE.

WAIT_MEM:
- Hold until `mem_rvalid`, then latch the extended `mem_rdata` and go to WRITE.
- No timeout.

WRITE:
- `rf_we` = latched `rd_we` AND (latched `rd_addr != 0`).
- `rf_waddr` and `rf_wdata` are driven from the latched values.
- Next state is always IDLE.

Load extension applies only to the `MEM_IDX` path; `ld_mode` is ignored for other sources. Lanes are taken from the low 32 bits of `mem_rdata`.
- 000 LB: byte `addr_lo`, sign-extended to `DATA_W`.
- 001 LH: halfword `addr_lo[1]`, sign-extended.
- 010 LW: bits [31:0], sign-extended.
- 100 LBU: byte `addr_lo`, zero-extended.
- 101 LHU: halfword `addr_lo[1]`, zero-extended.
- Any other code: treated as LW.
- `addr_lo[0]=1` with LH/LHU: the halfword is still selected by `addr_lo[1]`; misalignment is handled upstream.

Outputs:
- `rf_waddr` and `rf_wdata` hold their last written values outside WRITE; only `rf_we` qualifies them.
- `rf_we` is never asserted for x0.

## Timing
- Reset values: state IDLE; `in_ready`=1, `rf_we`=0, `rf_waddr`=0, `rf_wdata`=0, `sel_err`=0.
- Reset mid-operation: `rf_we` drops immediately (asynchronous) and any pending request is discarded.
- Non-memory latency: accept in cycle N gives `rf_we` in cycle N+1 and `in_ready` again in N+2.
- Memory latency: `mem_rvalid` in cycle M (in IDLE-accept or WAIT_MEM) gives `rf_we` in M+1.
- Throughput: at most one write-back every 2 cycles.
- All outputs are registered except `in_ready`, which is decoded from state.

## Test plan
- Reset while in WAIT_MEM: assert `rst_n`=0 mid-wait → `rf_we`=0 immediately, state IDLE, `in_ready`=1; a later `mem_rvalid` produces no write.
- ALU path: `wb_sel`=0, src0=0x1234_5678, rd=5, `rd_we`=1 → next cycle `rf_we`=1, `rf_waddr`=5, `rf_wdata`=0x1234_5678; `in_ready`=0 that cycle and 1 the cycle after.
- Late load, LB: `wb_sel`=`MEM_IDX`, `ld_mode`=000, `addr_lo`=2, `mem_rvalid` 3 cycles later with `mem_rdata`=0x0080_0000 → `rf_wdata`=0xFFFF_FF80 one cycle after `mem_rvalid`; `in_ready`=0 throughout the wait.
- Same-cycle load, LHU: `ld_mode`=101, `addr_lo`=2, `mem_rdata`=0x8001_0000 with `mem_rvalid` asserted at accept → `rf_wdata`=0x0000_8001 next cycle.
- x0 write suppression: rd=0, `rd_we`=1, `wb_sel`=2 → `rf_we` stays 0 and the FSM still returns to IDLE.
- Out-of-range select: `NUM_SRC`=3, `wb_sel`=3 → `sel_err` pulses once, `rf_wdata`=0, `rf_we`=1 for a nonzero rd.

Source files
------------

// File: rtl/wb_stage_if.sv
// Write-back stage bus: request side from execute/memory, result side to the register file.
interface wb_stage_if #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int RA_W    = 5
);
    logic                      in_valid;
    logic                      in_ready;
    logic [SEL_W-1:0]          wb_sel;
    logic [NUM_SRC*DATA_W-1:0] src_data;
    logic [RA_W-1:0]           rd_addr;
    logic                      rd_we;
    logic [2:0]                ld_mode;
    logic [1:0]                addr_lo;
    logic                      mem_rvalid;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      rf_we;
    logic [RA_W-1:0]           rf_waddr;
    logic [DATA_W-1:0]         rf_wdata;
    logic                      sel_err;

    modport master (
        output in_valid, wb_sel, src_data, rd_addr, rd_we, ld_mode, addr_lo,
               mem_rvalid, mem_rdata,
        input  in_ready, rf_we, rf_waddr, rf_wdata, sel_err
    );

    modport slave (
        input  in_valid, wb_sel, src_data, rd_addr, rd_we, ld_mode, addr_lo,
               mem_rvalid, mem_rdata,
        output in_ready, rf_we, rf_waddr, rf_wdata, sel_err
    );
endinterface

// File: rtl/wb_stage.sv
// Sequential write-back stage: picks one of NUM_SRC sources, extends load data,
// waits for late memory data and issues a single-cycle register-file write.
module wb_stage #(
    parameter int DATA_W  = 32,
    parameter int NUM_SRC = 4,
    parameter int MEM_IDX = 1,
    parameter int SEL_W   = $clog2(NUM_SRC),
    parameter int RA_W    = 5
) (
    input logic      clk,
    input logic      rst_n,
    wb_stage_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    state_t            state;
    logic [RA_W-1:0]   rd_addr_q;
    logic              rd_we_q;
    logic [2:0]        ld_mode_q;
    logic [1:0]        addr_lo_q;

    logic [DATA_W-1:0] src_pick;
    logic              sel_mem;
    logic              sel_bad;

    // Byte/halfword lane extraction from the low word, then sign or zero extension.
    function automatic logic [DATA_W-1:0] load_extend(
        input logic [2:0]        mode,
        input logic [1:0]        lo,
        input logic [DATA_W-1:0] rdata
    );
        logic [31:0] word;
        logic [7:0]  lane_b;
        logic [15:0] lane_h;
        word   = rdata[31:0];
        lane_b = word[{lo, 3'b000} +: 8];
        lane_h = lo[1] ? word[31:16] : word[15:0];
        case (mode)
            3'b000:  load_extend = DATA_W'($signed(lane_b));
            3'b001:  load_extend = DATA_W'($signed(lane_h));
            3'b100:  load_extend = DATA_W'(lane_b);
            3'b101:  load_extend = DATA_W'(lane_h);
            default: load_extend = DATA_W'($signed(word));
        endcase
    endfunction

    // Source decode; an out-of-range select matches no source and yields zero.
    always_comb begin
        src_pick = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (32'(bus.wb_sel) == i) begin
                src_pick = bus.src_data[i*DATA_W +: DATA_W];
            end
        end
        sel_mem = (32'(bus.wb_sel) == MEM_IDX);
        sel_bad = (32'(bus.wb_sel) >= NUM_SRC);
    end

    assign bus.in_ready = (state == IDLE);

    // Control FSM with registered write port; outputs only change on entry to WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            rd_addr_q    <= '0;
            rd_we_q      <= 1'b0;
            ld_mode_q    <= 3'b000;
            addr_lo_q    <= 2'b00;
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            bus.sel_err  <= 1'b0;
        end else begin
            bus.rf_we   <= 1'b0;
            bus.sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rd_addr_q   <= bus.rd_addr;
                        rd_we_q     <= bus.rd_we;
                        ld_mode_q   <= bus.ld_mode;
                        addr_lo_q   <= bus.addr_lo;
                        bus.sel_err <= sel_bad;
                        if (sel_mem && !bus.mem_rvalid) begin
                            state <= WAIT_MEM;
                        end else begin
                            state        <= WRITE;
                            bus.rf_we    <= bus.rd_we && (bus.rd_addr != '0);
                            bus.rf_waddr <= bus.rd_addr;
                            bus.rf_wdata <= sel_mem
                                ? load_extend(bus.ld_mode, bus.addr_lo, bus.mem_rdata)
                                : src_pick;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_rvalid) begin
                        state        <= WRITE;
                        bus.rf_we    <= rd_we_q && (rd_addr_q != '0);
                        bus.rf_waddr <= rd_addr_q;
                        bus.rf_wdata <= load_extend(ld_mode_q, addr_lo_q, bus.mem_rdata);
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Testbench for wb_stage: directed literal checks plus randomized traffic
// compared every cycle against a transaction-level reference model.
module tb_wb_stage;

    localparam int DATA_W  = 32;
    localparam int NUM_SRC = 3;
    localparam int MEM_IDX = 1;
    localparam int SEL_W   = 2;
    localparam int RA_W    = 5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wb_stage_if #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .RA_W(RA_W)) bus ();

    wb_stage #(
        .DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .MEM_IDX(MEM_IDX), .SEL_W(SEL_W), .RA_W(RA_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;
    bit check_en     = 1'b0;

    // Reference model state: a pending request and what the outputs must show.
    bit          m_wait    = 1'b0;
    bit          m_write   = 1'b0;
    int          m_sel;
    logic [4:0]  p_rd      = '0;
    bit          p_we      = 1'b0;
    int          p_mode    = 0;
    int          p_lo      = 0;
    bit          exp_ready = 1'b1;
    bit          exp_we    = 1'b0;
    bit          exp_err   = 1'b0;
    logic [4:0]  exp_waddr = '0;
    logic [31:0] exp_wdata = '0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // RISC-V load result computed with shifts, masks and two's-complement arithmetic.
    function automatic logic [31:0] model_load(input int mode, input int lo,
                                               input logic [31:0] word);
        logic [31:0] b;
        logic [31:0] h;
        b = (word >> (8 * lo)) & 32'hFF;
        h = (word >> (16 * (lo / 2))) & 32'hFFFF;
        case (mode)
            0:       return (b >= 32'd128)   ? b - 32'd256   : b;
            1:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            4:       return b;
            5:       return h;
            default: return word;
        endcase
    endfunction

    task automatic model_finish(input logic [31:0] data);
        m_write   = 1'b1;
        m_wait    = 1'b0;
        exp_we    = p_we && (p_rd != 5'd0);
        exp_waddr = p_rd;
        exp_wdata = data;
    endtask

    // Reference model: one request in flight, completed by a single write cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_wait    = 1'b0;
            m_write   = 1'b0;
            exp_we    = 1'b0;
            exp_err   = 1'b0;
            exp_ready = 1'b1;
        end else begin
            exp_err = 1'b0;
            if (m_write) begin
                m_write = 1'b0;
                exp_we  = 1'b0;
            end else if (m_wait) begin
                if (bus.mem_rvalid)
                    model_finish(model_load(p_mode, p_lo, bus.mem_rdata));
            end else if (bus.in_valid) begin
                p_rd   = bus.rd_addr;
                p_we   = bus.rd_we;
                p_mode = int'(bus.ld_mode);
                p_lo   = int'(bus.addr_lo);
                m_sel  = int'(bus.wb_sel);
                if (m_sel >= NUM_SRC) begin
                    exp_err = 1'b1;
                    model_finish(32'd0);
                end else if (m_sel == MEM_IDX) begin
                    if (bus.mem_rvalid)
                        model_finish(model_load(p_mode, p_lo, bus.mem_rdata));
                    else
                        m_wait = 1'b1;
                end else begin
                    model_finish(bus.src_data[m_sel*32 +: 32]);
                end
            end
            exp_ready = !(m_wait || m_write);
        end
    end

    // Every-cycle comparison of the DUT against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en && rst_n) begin
            checkOutput("model in_ready", 32'(bus.in_ready), 32'(exp_ready));
            checkOutput("model rf_we",    32'(bus.rf_we),    32'(exp_we));
            checkOutput("model sel_err",  32'(bus.sel_err),  32'(exp_err));
            if (exp_we) begin
                checkOutput("model rf_waddr", 32'(bus.rf_waddr), 32'(exp_waddr));
                checkOutput("model rf_wdata", bus.rf_wdata, exp_wdata);
            end
        end
    end

    task automatic applyStimulus(input bit valid, input int sel, input logic [4:0] rd,
                                 input bit we, input int mode, input int lo,
                                 input bit rvalid, input logic [31:0] rdata);
        @(posedge clk);
        #2;
        bus.in_valid   = valid;
        bus.wb_sel     = 2'(sel);
        bus.rd_addr    = rd;
        bus.rd_we      = we;
        bus.ld_mode    = 3'(mode);
        bus.addr_lo    = 2'(lo);
        bus.mem_rvalid = rvalid;
        bus.mem_rdata  = rdata;
    endtask

    task automatic idleCycle(input bit rvalid, input logic [31:0] rdata);
        applyStimulus(1'b0, 0, 5'd0, 1'b0, 0, 0, rvalid, rdata);
    endtask

    initial begin
        bus.in_valid   = 1'b0;
        bus.wb_sel     = '0;
        bus.src_data   = {32'hCAFE_F00D, 32'hDEAD_BEEF, 32'h1234_5678};
        bus.rd_addr    = '0;
        bus.rd_we      = 1'b0;
        bus.ld_mode    = 3'b000;
        bus.addr_lo    = 2'b00;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;

        #3;
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset rf_we",    32'(bus.rf_we),    32'd0);
        checkOutput("reset rf_waddr", 32'(bus.rf_waddr), 32'd0);
        checkOutput("reset rf_wdata", bus.rf_wdata,      32'd0);
        checkOutput("reset sel_err",  32'(bus.sel_err),  32'd0);
        @(posedge clk);
        #2;
        rst_n    = 1'b1;
        check_en = 1'b1;

        // ALU path
        applyStimulus(1'b1, 0, 5'd5, 1'b1, 0, 0, 1'b0, 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("alu rf_we",    32'(bus.rf_we),    32'd1);
        checkOutput("alu rf_waddr", 32'(bus.rf_waddr), 32'd5);
        checkOutput("alu rf_wdata", bus.rf_wdata,      32'h1234_5678);
        checkOutput("alu busy",     32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("alu ready",    32'(bus.in_ready), 32'd1);

        // Late LB load, data three cycles after accept
        applyStimulus(1'b1, MEM_IDX, 5'd7, 1'b1, 0, 2, 1'b0, 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("lb wait1 ready", 32'(bus.in_ready), 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("lb wait2 ready", 32'(bus.in_ready), 32'd0);
        idleCycle(1'b1, 32'h0080_0000);
        @(negedge clk);
        checkOutput("lb wait3 ready", 32'(bus.in_ready), 32'd0);
        checkOutput("lb wait3 rf_we", 32'(bus.rf_we),    32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("lb rf_we",     32'(bus.rf_we), 32'd1);
        checkOutput("lb rf_wdata",  bus.rf_wdata,   32'hFFFF_FF80);

        // Same-cycle LHU load
        applyStimulus(1'b1, MEM_IDX, 5'd9, 1'b1, 5, 2, 1'b1, 32'h8001_0000);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("lhu rf_we",    32'(bus.rf_we), 32'd1);
        checkOutput("lhu rf_wdata", bus.rf_wdata,   32'h0000_8001);

        // x0 suppression
        applyStimulus(1'b1, 2, 5'd0, 1'b1, 0, 0, 1'b0, 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("x0 rf_we",   32'(bus.rf_we),    32'd0);
        checkOutput("x0 busy",    32'(bus.in_ready), 32'd0);
        @(negedge clk);
        checkOutput("x0 ready",   32'(bus.in_ready), 32'd1);

        // Out-of-range select
        applyStimulus(1'b1, 3, 5'd4, 1'b1, 0, 0, 1'b0, 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("oor sel_err",  32'(bus.sel_err), 32'd1);
        checkOutput("oor rf_we",    32'(bus.rf_we),   32'd1);
        checkOutput("oor rf_wdata", bus.rf_wdata,     32'd0);
        @(negedge clk);
        checkOutput("oor sel_err pulse", 32'(bus.sel_err), 32'd0);

        // Reset while waiting for memory; later rvalid must not write
        applyStimulus(1'b1, MEM_IDX, 5'd3, 1'b1, 2, 0, 1'b0, 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("rst wait busy", 32'(bus.in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst wait rf_we", 32'(bus.rf_we),    32'd0);
        checkOutput("rst wait ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idleCycle(1'b1, 32'hFFFF_FFFF);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("rst late rvalid rf_we", 32'(bus.rf_we),    32'd0);
        checkOutput("rst late ready",        32'(bus.in_ready), 32'd1);

        // Reset during the write cycle drops rf_we at once
        applyStimulus(1'b1, 2, 5'd6, 1'b1, 0, 0, 1'b0, 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        checkOutput("rst write rf_we before", 32'(bus.rf_we),    32'd1);
        checkOutput("rst write rf_wdata",     bus.rf_wdata,      32'hCAFE_F00D);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst write rf_we after",  32'(bus.rf_we),    32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 600; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                          5'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                          int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                          ($urandom_range(0, 2) == 0), $urandom);
            bus.src_data = {$urandom, $urandom, $urandom};
            rst_n        = ($urandom_range(0, 79) != 0);
        end
        idleCycle(1'b0, 32'd0);
        rst_n = 1'b1;
        idleCycle(1'b0, 32'd0);
        idleCycle(1'b0, 32'd0);
        @(negedge clk);
        check_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
